medidor_freq: RTL and testbench

Frequency meter: counts rising edges of an external signal over a fixed gate window of `CLK_50` cycles. At the end of each window it publishes the count as a frequency word with a one-cycle valid strobe. It is the measuring counterpart of the clock divider. With the default gate of 50 000 000 cycles (1 s at 50 MHz), `FREQ` reads directly in Hz. Typical use: driving the seven-segment/LED display path or checking divider outputs on the FPGA kit.

---
 rtl/freq_pkg.sv | 13 +
 rtl/detecta_borda.sv | 59 +++++
 rtl/medidor_freq.sv | 88 ++++++++
 tb/tb_medidor_freq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants and sizing helper for the frequency meter
package freq_pkg;

    // One-second gate at the 50 MHz kit clock, so FREQ reads in Hz
    localparam int GATE_1S   = 50_000_000;
    localparam int CNT_W_DEF = 32;

    // Width of a counter that must hold 0 .. gate_cycles-1
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/detecta_borda.sv
// rtl/detecta_borda.sv - optional synchronizer plus registered rising-edge pulse (MEDIDOR_FREQ_SYNC_EN)
module detecta_borda (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic cur;

`ifdef MEDIDOR_FREQ_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Two-stage shift toward the metastability-safe sample
    always_comb begin
        sync_d = {sync_q[0], din};
    end

    // Synchronizer flops, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign cur = sync_q[1];
`else
    // Input is already synchronous to clk (e.g. a divider output)
    assign cur = din;
`endif

    logic prev_q;
    logic prev_d;
    logic pulse_q;
    logic pulse_d;

    // Rising edge = current high while the previous sample was low
    always_comb begin
        prev_d  = cur;
        pulse_d = cur & ~prev_q;
    end

    // Previous-value flop and registered one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/medidor_freq.sv
// rtl/medidor_freq.sv - gated edge counter publishing a frequency word each window (MEDIDOR_FREQ_SYNC_EN selects input synchronizer)
module medidor_freq
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_1S,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             CLK_50,
    input  logic             RST,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] FREQ,
    output logic             VALID,
    output logic             OVF
);

    localparam int                GCNT_W    = gate_cnt_w(GATE_CYCLES);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ECNT_MAX  = '1;

    logic edge_pulse;

    detecta_borda u_borda (
        .clk   (CLK_50),
        .rst   (RST),
        .din   (SIG_IN),
        .pulse (edge_pulse)
    );

    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic              terminal;
    logic              at_max;
    logic              sat_hit;
    logic [CNT_W-1:0]  ecnt_inc;

    // Next state: free-running gate, saturating edge count, and publish on the terminal cycle
    always_comb begin
        terminal = (gcnt_q == GCNT_LAST);
        at_max   = (ecnt_q == ECNT_MAX);
        sat_hit  = edge_pulse & at_max;
        ecnt_inc = (edge_pulse & ~at_max) ? ecnt_q + CNT_W'(1) : ecnt_q;

        gcnt_d  = terminal ? '0 : gcnt_q + GCNT_W'(1);
        ecnt_d  = ecnt_inc;
        sat_d   = sat_q | sat_hit;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        // An edge landing in the terminal cycle closes out with this window
        if (terminal) begin
            freq_d  = ecnt_inc;
            ovf_d   = sat_q | sat_hit;
            valid_d = 1'b1;
            ecnt_d  = '0;
            sat_d   = 1'b0;
        end
    end

    // State and output registers; reset wins over a coincident terminal update
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            gcnt_q  <= '0;
            ecnt_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            ecnt_q  <= ecnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign FREQ  = freq_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_medidor_freq.sv
// tb/tb_medidor_freq.sv - self-checking bench for medidor_freq with a window-level edge model
module tb_medidor_freq;

    localparam int GA = 10;
    localparam int WA = 8;
    localparam int GB = 20;
    localparam int WB = 3;
`ifdef MEDIDOR_FREQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int MAX_A = (1 << WA) - 1;
    localparam int MAX_B = (1 << WB) - 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          sig_a = 1'b0;
    logic          sig_b = 1'b0;
    logic [WA-1:0] freq_a;
    logic          valid_a;
    logic          ovf_a;
    logic [WB-1:0] freq_b;
    logic          valid_b;
    logic          ovf_b;

    int checks    = 0;
    int failures  = 0;
    int p         = 0;
    int pulse_pos = -1;
    bit samp_a[$];
    bit samp_b[$];
    int exp_freq_a = 0;
    int exp_ovf_a  = 0;
    int exp_freq_b = 0;
    int exp_ovf_b  = 0;

    medidor_freq #(.GATE_CYCLES(GA), .CNT_W(WA)) dut_a (
        .CLK_50 (clk),
        .RST    (rst),
        .SIG_IN (sig_a),
        .FREQ   (freq_a),
        .VALID  (valid_a),
        .OVF    (ovf_a)
    );

    medidor_freq #(.GATE_CYCLES(GB), .CNT_W(WB)) dut_b (
        .CLK_50 (clk),
        .RST    (rst),
        .SIG_IN (sig_b),
        .FREQ   (freq_b),
        .VALID  (valid_b),
        .OVF    (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp_v, p);
        end
    endtask

    // Rising edges sampled at index k reach the counter at posedge k+LAT;
    // count those landing inside the window that ends at posedge 'last'.
    function automatic int win_edges(input bit s[$], input int gate, input int last);
        int n = 0;
        for (int k = 0; k < s.size(); k++) begin
            if (s[k] && (k == 0 || !s[k-1]) &&
                (k + LAT >= last - gate + 1) && (k + LAT <= last))
                n++;
        end
        return n;
    endfunction

    function automatic bit gen(input int mode, input int idx);
        case (mode)
            1:       return (idx % 2) == 0;
            2:       return (idx % 4) < 2;
            3:       return 1'($urandom_range(0, 1));
            4:       return idx == pulse_pos;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input int ma, input int mb);
        int n;
        @(negedge clk);
        rst   = 1'b0;
        sig_a = gen(ma, p);
        sig_b = gen(mb, p);
        samp_a.push_back(sig_a);
        samp_b.push_back(sig_b);
        @(posedge clk);
        #1;
        if (p % GA == GA - 1) begin
            n          = win_edges(samp_a, GA, p);
            exp_freq_a = (n > MAX_A) ? MAX_A : n;
            exp_ovf_a  = (n > MAX_A) ? 1 : 0;
        end
        if (p % GB == GB - 1) begin
            n          = win_edges(samp_b, GB, p);
            exp_freq_b = (n > MAX_B) ? MAX_B : n;
            exp_ovf_b  = (n > MAX_B) ? 1 : 0;
        end
        chk("valid_a", valid_a, (p % GA) == GA - 1);
        chk("freq_a",  freq_a,  exp_freq_a);
        chk("ovf_a",   ovf_a,   exp_ovf_a);
        chk("valid_b", valid_b, (p % GB) == GB - 1);
        chk("freq_b",  freq_b,  exp_freq_b);
        chk("ovf_b",   ovf_b,   exp_ovf_b);
        p++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid_a", valid_a, 0);
        chk("rst_freq_a",  freq_a,  0);
        chk("rst_ovf_a",   ovf_a,   0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_freq_b",  freq_b,  0);
        chk("rst_ovf_b",   ovf_b,   0);
        samp_a.delete();
        samp_b.delete();
        p          = 0;
        exp_freq_a = 0;
        exp_ovf_a  = 0;
        exp_freq_b = 0;
        exp_ovf_b  = 0;
    endtask

    initial begin
        // Idle input: VALID every window with zero counts
        do_reset();
        repeat (30) cyc(0, 0);

        // Toggle every cycle; B saturates at 7 with OVF, then drops to zero
        do_reset();
        repeat (40) cyc(1, 1);
        repeat (20) cyc(3, 0);

        // Period 4 on A puts edges into terminal cycles; random on both
        repeat (40) cyc(2, 3);
        repeat (60) cyc(3, 3);

        // Reset mid-window after three counted edges discards the partial count
        do_reset();
        repeat (6) cyc(1, 1);
        do_reset();
        repeat (20) cyc(0, 0);

        // Single pulse just inside / just outside the first window (edge latency)
        do_reset();
        pulse_pos = GA - 1 - LAT;
        repeat (20) cyc(4, 0);
        do_reset();
        pulse_pos = GA - LAT;
        repeat (20) cyc(4, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
